// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: registered single-cycle ops plus iterative unsigned
// multiply/divide into HI/LO, with a valid/ready handshake and flush.
module alu_mc #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             res_valid,
   output logic [WIDTH-1:0] alures,
   output logic             zero,
   output logic             ovf
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   localparam logic [3:0] OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_MFHI  = 4'b1110;
   localparam logic [3:0] OP_MFLO  = 4'b1111;

   state_t                 state_q, state_d;
   logic [SHW-1:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]       opnd_q, opnd_d;
   logic [2*WIDTH-1:0]     work_q, work_d;
   logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]       alures_q, alures_d;
   logic                   res_valid_q, res_valid_d;
   logic                   zero_q, zero_d, ovf_q, ovf_d;

   function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa, sb;
      logic [SHW-1:0]          sh;
      sa = $signed(a);
      sb = $signed(b);
      sh = a[SHW-1:0];
      case (op)
         4'b0000: single_op = b << (WIDTH/2);
         4'b0001: single_op = a | b;
         4'b0010: single_op = a + b;
         4'b0011: single_op = a & b;
         4'b0100: single_op = a ^ b;
         4'b0101: single_op = ~(a | b);
         4'b0110: single_op = a - b;
         4'b0111: single_op = {{(WIDTH-1){1'b0}}, (sa < sb)};
         4'b1000: single_op = {{(WIDTH-1){1'b0}}, (a < b)};
         4'b1001: single_op = b << sh;
         4'b1010: single_op = b >> sh;
         4'b1011: single_op = $unsigned(sb >>> sh);
         default: single_op = '0;
      endcase
   endfunction

   // Signed overflow: operands of equal sign (after negating B for SUB)
   // producing a result of the other sign.
   function automatic logic signed_ovf(input logic [3:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] r);
      case (op)
         4'b0010: signed_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         4'b0110: signed_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         default: signed_ovf = 1'b0;
      endcase
   endfunction

   // Shift-add step: work holds {partial product high, multiplier remainder}.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_nxt;
   assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_nxt = {mul_sum, work_q[WIDTH-1:1]};

   // Restoring step: work holds {remainder, dividend/quotient}. A zero divisor
   // always "fits", naturally giving quotient all ones and remainder = dividend.
   logic [WIDTH:0]       div_sh, div_rem;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_nxt;
   assign div_sh  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_ge  = div_sh >= {1'b0, opnd_q};
   assign div_rem = div_ge ? (div_sh - {1'b0, opnd_q}) : div_sh;
   assign div_nxt = {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], div_ge};

   always_comb begin
      logic [2*WIDTH-1:0] step;
      logic [WIDTH-1:0]   r;
      state_d     = state_q;
      cnt_d       = cnt_q;
      opnd_d      = opnd_q;
      work_d      = work_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      res_valid_d = 1'b0;
      alures_d    = alures_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      step        = (state_q == S_MUL) ? mul_nxt : div_nxt;
      r           = '0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cnt_d = '0;
               case (aluop)
                  OP_MULTU: begin
                     state_d = S_MUL;
                     opnd_d  = SrcA;
                     work_d  = {{WIDTH{1'b0}}, SrcB};
                  end
                  OP_DIVU: begin
                     state_d = S_DIV;
                     opnd_d  = SrcB;
                     work_d  = {{WIDTH{1'b0}}, SrcA};
                  end
                  default: begin
                     if (aluop == OP_MFHI)      r = hi_q;
                     else if (aluop == OP_MFLO) r = lo_q;
                     else                       r = single_op(aluop, SrcA, SrcB);
                     res_valid_d = 1'b1;
                     alures_d    = r;
                     zero_d      = (r == '0);
                     ovf_d       = signed_ovf(aluop, SrcA, SrcB, r);
                  end
               endcase
            end
         end
         default: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               work_d = step;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == SHW'(WIDTH-1)) begin
                  state_d     = S_IDLE;
                  hi_d        = step[2*WIDTH-1:WIDTH];
                  lo_d        = step[WIDTH-1:0];
                  res_valid_d = 1'b1;
                  alures_d    = step[WIDTH-1:0];
                  zero_d      = (step[WIDTH-1:0] == '0);
                  ovf_d       = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         res_valid_q <= 1'b0;
         alures_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         res_valid_q <= res_valid_d;
         alures_q    <= alures_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   // Iteration working registers are fully reloaded at every accept.
   always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      work_q <= work_d;
   end

   assign in_ready  = (state_q == S_IDLE);
   assign res_valid = res_valid_q;
   assign alures    = alures_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   aluop = 4'd0;
   logic [W-1:0] SrcA = '0;
   logic [W-1:0] SrcB = '0;
   logic         flush = 1'b0;
   logic         res_valid;
   logic [W-1:0] alures;
   logic         zero;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
      .res_valid(res_valid), .alures(alures), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge, after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      aluop    = op;
      SrcA     = a;
      SrcB     = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // lat counts clock edges from the accept edge to the edge sampling res_valid.
   task automatic wait_res(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!res_valid && lat < 100) begin
         if (!in_ready) busy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_single(input string tag, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_r, input logic exp_z,
                               input logic exp_o);
      issue(op, a, b);
      check({tag, ".vld"}, 64'(res_valid), 64'd1);
      check({tag, ".res"}, 64'(alures), 64'(exp_r));
      check({tag, ".zero"}, 64'(zero), 64'(exp_z));
      check({tag, ".ovf"}, 64'(ovf), 64'(exp_o));
   endtask

   initial begin
      int lat, busy, seen;
      #2;
      check("rst.res", 64'(alures), 64'd0);
      check("rst.vld", 64'(res_valid), 64'd0);
      check("rst.zero", 64'(zero), 64'd0);
      check("rst.ovf", 64'(ovf), 64'd0);
      check("rst.rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check_single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
      @(negedge clk);
      check("idle.vld", 64'(res_valid), 64'd0);
      check("idle.hold", 64'(alures), 64'h8000_0000);
      check_single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
      check_single("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      check_single("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
      check_single("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
      check_single("sra", 4'b1011, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
      check_single("srl", 4'b1010, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
      check_single("sll", 4'b1001, 32'd31, 32'h3, 32'h8000_0000, 1'b0, 1'b0);
      check_single("lui", 4'b0000, 32'hDEAD, 32'h1234, 32'h1234_0000, 1'b0, 1'b0);
      check_single("nor", 4'b0101, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_single("xor", 4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1'b0);
      check_single("and", 4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);
      check_single("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0);
      flush = 1'b1;
      check_single("flush_idle", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
      flush = 1'b0;

      issue(4'b1100, 32'hFFFF_FFFF, 32'd2);
      wait_res(lat, busy);
      check("mul.lat", 64'(lat), 64'd33);
      check("mul.busy", 64'(busy), 64'd32);
      check("mul.lo", 64'(alures), 64'hFFFF_FFFE);
      check("mul.rdy", 64'(in_ready), 64'd1);
      check_single("mul.mfhi", 4'b1110, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0);
      check_single("mul.mflo", 4'b1111, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);

      issue(4'b1101, 32'd100, 32'd7);
      wait_res(lat, busy);
      check("div.lat", 64'(lat), 64'd33);
      check("div.lo", 64'(alures), 64'd14);
      check_single("div.mfhi", 4'b1110, 32'h0, 32'h0, 32'd2, 1'b0, 1'b0);

      issue(4'b1101, 32'd7, 32'd0);
      wait_res(lat, busy);
      check("div0.lat", 64'(lat), 64'd33);
      check("div0.lo", 64'(alures), 64'hFFFF_FFFF);
      check_single("div0.mfhi", 4'b1110, 32'h0, 32'h0, 32'd7, 1'b0, 1'b0);

      issue(4'b1100, 32'd3, 32'd4);
      seen = 0;
      repeat (8) begin
         if (res_valid) seen++;
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush.vld", 64'(res_valid), 64'd0);
      check("flush.rdy", 64'(in_ready), 64'd1);
      repeat (30) begin
         if (res_valid) seen++;
         @(negedge clk);
      end
      check("flush.no_res", 64'(seen), 64'd0);
      check_single("flush.mflo", 4'b1111, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_single("flush.mfhi", 4'b1110, 32'h0, 32'h0, 32'd7, 1'b0, 1'b0);

      issue(4'b1101, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst.res", 64'(alures), 64'd0);
      check("arst.vld", 64'(res_valid), 64'd0);
      check("arst.zero", 64'(zero), 64'd0);
      check("arst.rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_single("arst.mfhi", 4'b1110, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_single("arst.mflo", 4'b1111, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
